icache_responder: RTL and testbench

Direct-mapped, blocking instruction cache that sits on the `i_cache` end of the fetch/decode cache interface. It accepts fetch addresses and returns one instruction word per hit, with address echo, to decode. On a miss it raises `cache_miss` and refills the whole line from a beat-based memory port. It is the responder for the fetch stage's initiator side.

---
 rtl/icache_responder_pkg.sv | 16 +
 rtl/icache_responder_if.sv | 22 ++
 rtl/icache_responder_data_ram.sv | 26 ++
 rtl/icache_responder.sv | 135 +++++++++++++
 tb/tb_icache_responder.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/icache_responder_pkg.sv
// Shared types for the direct-mapped instruction cache responder.
package com_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_FILL} icache_state_t;

  // Tags are held zero-extended to a fixed width so one struct fits any geometry.
  localparam int TAG_MAX = 64;

  typedef struct packed {
    logic               vld;
    logic [TAG_MAX-1:0] tag;
  } line_meta_t;

  function automatic int calc_beats(input int line_bytes, input int return_bytes);
    return line_bytes / return_bytes;
  endfunction
endpackage

// File: rtl/icache_responder_if.sv
// Fetch/decode cache interface; the cache is the responder on modport i_cache.
interface i_cache_if #(
  parameter int ADR_WIDTH    = 32,
  parameter int RETURN_BYTES = 4
);
  logic [ADR_WIDTH-1:0]      address;
  logic                      req_valid;
  logic [RETURN_BYTES*8-1:0] cache_data_out;
  logic [ADR_WIDTH-1:0]      cache_adr_out;
  logic                      data_valid;
  logic                      cache_miss;

  modport i_cache (
    input  address, req_valid,
    output cache_data_out, cache_adr_out, data_valid, cache_miss
  );

  modport fetch (
    output address, req_valid,
    input  cache_data_out, cache_adr_out, data_valid, cache_miss
  );
endinterface

// File: rtl/icache_responder_data_ram.sv
// Line data store: one fill write port, one registered lookup read port (SRAM-mappable).
module icache_data_ram #(
  parameter int AW = 8,
  parameter int W  = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] r_mem [2**AW];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read register only advances on hits, so it doubles as the response data flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       o_rdata <= '0;
    else if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/icache_responder.sv
// Direct-mapped blocking icache: 1-cycle hits, whole-line refill on miss.
module icache_responder
  import com_pkg::*;
#(
  parameter int ADR_WIDTH    = 32,
  parameter int RETURN_BYTES = 4,
  parameter int LINE_BYTES   = 16,
  parameter int NUM_LINES    = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  i_cache_if.i_cache                cache_if,
  input  logic                      flush,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic [ADR_WIDTH-1:0]      mem_req_adr,
  input  logic                      mem_rsp_valid,
  input  logic [RETURN_BYTES*8-1:0] mem_rsp_data
);
  localparam int OFF   = $clog2(LINE_BYTES);
  localparam int IDX   = $clog2(NUM_LINES);
  localparam int WSB   = $clog2(RETURN_BYTES);
  localparam int TAG   = ADR_WIDTH - IDX - OFF;
  localparam int BEATS = calc_beats(LINE_BYTES, RETURN_BYTES);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  icache_state_t r_state, w_next;
  logic [BW-1:0]        r_beat;
  logic [ADR_WIDTH-1:0] r_miss_adr;
  logic                 r_flushed;
  logic                 r_dv;
  logic [ADR_WIDTH-1:0] r_adr_out;
  line_meta_t           r_meta [NUM_LINES];

  logic [IDX-1:0] w_idx, w_fidx;
  logic [TAG-1:0] w_tag, w_ftag;
  logic [BW-1:0]  w_word;
  line_meta_t     w_meta;
  logic           w_lookup, w_hit, w_we, w_last;

  assign w_idx    = cache_if.address[OFF+IDX-1:OFF];
  assign w_tag    = cache_if.address[ADR_WIDTH-1:OFF+IDX];
  assign w_fidx   = r_miss_adr[OFF+IDX-1:OFF];
  assign w_ftag   = r_miss_adr[ADR_WIDTH-1:OFF+IDX];
  assign w_meta   = r_meta[w_idx];
  assign w_lookup = (r_state == ST_IDLE) && cache_if.req_valid;
  assign w_hit    = w_meta.vld && (w_meta.tag == TAG_MAX'(w_tag));
  assign w_we     = (r_state == ST_FILL) && mem_rsp_valid;
  assign w_last   = w_we && (r_beat == BW'(BEATS - 1));

  generate
    if (BEATS > 1) begin : g_wsel
      assign w_word = cache_if.address[OFF-1:WSB];
    end else begin : g_wsel1
      assign w_word = '0;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    mem_req_valid = 1'b0;
    case (r_state)
      ST_IDLE: if (w_lookup && !w_hit) w_next = ST_REQ;
      ST_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) w_next = ST_FILL;
      end
      ST_FILL: if (w_last) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_beat     <= '0;
      r_miss_adr <= '0;
      r_flushed  <= 1'b0;
    end else begin
      if (w_lookup && !w_hit) begin
        r_miss_adr <= {w_tag, w_idx, {OFF{1'b0}}};
        r_flushed  <= 1'b0;
      end else if ((r_state != ST_IDLE) && flush) begin
        r_flushed  <= 1'b1;
      end
      if ((r_state == ST_REQ) && mem_req_ready) r_beat <= '0;
      else if (w_we)                            r_beat <= r_beat + 1'b1;
    end
  end

  // A flush anywhere in the miss window leaves the refilled line invalid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_LINES; i++) r_meta[i] <= '0;
    end else begin
      if (flush)
        for (int i = 0; i < NUM_LINES; i++) r_meta[i].vld <= 1'b0;
      if (w_last)
        r_meta[w_fidx] <= '{vld: !(r_flushed || flush), tag: TAG_MAX'(w_ftag)};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dv      <= 1'b0;
      r_adr_out <= '0;
    end else begin
      r_dv <= w_lookup && w_hit;
      if (w_lookup && w_hit) r_adr_out <= cache_if.address;
    end
  end

  icache_data_ram #(
    .AW (IDX + BW),
    .W  (RETURN_BYTES * 8)
  ) u_data_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_waddr ({w_fidx, r_beat}),
    .i_wdata (mem_rsp_data),
    .i_re    (w_lookup && w_hit),
    .i_raddr ({w_idx, w_word}),
    .o_rdata (cache_if.cache_data_out)
  );

  assign cache_if.data_valid    = r_dv;
  assign cache_if.cache_adr_out = r_adr_out;
  assign cache_if.cache_miss    = (r_state != ST_IDLE);
  assign mem_req_adr            = r_miss_adr;
endmodule

// File: tb/tb_icache_responder.sv
// Bench for icache_responder: directed scenarios plus random traffic against a line-level cache model.
module tb_icache_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_adr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: per-index valid/tag/words, backing memory by byte address.
  bit          m_vld [64];
  logic [21:0] m_tag [64];
  logic [31:0] m_data [64][4];
  logic [31:0] bmem [int];

  int k_stall = 0, k_gap = 0, k_flush_beat = -1, k_rst_beat = -1, k_flush_req = 0;

  i_cache_if #(.ADR_WIDTH(32), .RETURN_BYTES(4)) cif ();

  icache_responder #(
    .ADR_WIDTH(32), .RETURN_BYTES(4), .LINE_BYTES(16), .NUM_LINES(64)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cache_if      (cif),
    .flush         (flush),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_adr   (mem_req_adr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] line, input int b);
    int key;
    key = int'(line) + 4 * b;
    if (bmem.exists(key)) return bmem[key];
    return (line * 32'h9E37_79B1) ^ (32'h0101_0101 * b);
  endfunction

  task automatic model_flush();
    for (int i = 0; i < 64; i++) m_vld[i] = 1'b0;
  endtask

  task automatic serve(input logic [31:0] line, input string nm);
    bit fl;
    int idx;
    fl  = 1'b0;
    idx = int'(line[9:4]);
    n_chk++;
    if (mem_req_valid !== 1'b1 || mem_req_adr !== line) begin
      n_err++;
      $display("FAIL %s_req got valid=%b adr=%h exp valid=1 adr=%h", nm, mem_req_valid, mem_req_adr, line);
    end
    repeat (k_stall) begin
      @(posedge clk); #1;
      n_chk++;
      if (mem_req_valid !== 1'b1 || mem_req_adr !== line || cif.cache_miss !== 1'b1) begin
        n_err++;
        $display("FAIL %s_stall got valid=%b adr=%h miss=%b exp 1 %h 1", nm, mem_req_valid, mem_req_adr, cif.cache_miss, line);
      end
    end
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      repeat ($urandom_range(k_gap, 0)) begin
        @(posedge clk); #1;
        n_chk++;
        if ({cif.data_valid, cif.cache_miss, mem_req_valid} !== 3'b010) begin
          n_err++;
          $display("FAIL %s_gap got dv/miss/req=%b%b%b exp 010", nm, cif.data_valid, cif.cache_miss, mem_req_valid);
        end
      end
      if (b == k_rst_beat) begin
        rst = 1'b1;
        #1;
        n_chk++;
        if ({cif.data_valid, cif.cache_miss, mem_req_valid, cif.cache_data_out, cif.cache_adr_out, mem_req_adr} !== '0) begin
          n_err++;
          $display("FAIL %s_rst_outs got dv=%b miss=%b req=%b data=%h adr=%h madr=%h exp all 0", nm,
                   cif.data_valid, cif.cache_miss, mem_req_valid, cif.cache_data_out, cif.cache_adr_out, mem_req_adr);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_flush();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        n_chk++;
        if ({cif.cache_miss, mem_req_valid, cif.data_valid} !== 3'b000) begin
          n_err++;
          $display("FAIL %s_stray got miss/req/dv=%b%b%b exp 000", nm, cif.cache_miss, mem_req_valid, cif.data_valid);
        end
        return;
      end
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = mem_word(line, b);
      m_data[idx][b] = mem_word(line, b);
      if (b == k_flush_beat) begin
        flush = 1'b1;
        fl    = 1'b1;
      end
      @(posedge clk); #1;
      mem_rsp_valid = 1'b0;
      flush = 1'b0;
      if (b == k_flush_beat) model_flush();
    end
    n_chk++;
    if ({cif.cache_miss, mem_req_valid, cif.data_valid} !== 3'b000) begin
      n_err++;
      $display("FAIL %s_done got miss/req/dv=%b%b%b exp 000", nm, cif.cache_miss, mem_req_valid, cif.data_valid);
    end
    m_tag[idx] = line[31:10];
    m_vld[idx] = !fl;
  endtask

  task automatic fetch(input logic [31:0] a, input string nm);
    int idx, w;
    bit hit;
    logic [1:0]  exp_st;
    logic [31:0] exp_d;
    idx    = int'(a[9:4]);
    w      = int'(a[3:2]);
    hit    = m_vld[idx] && (m_tag[idx] == a[31:10]);
    exp_st = hit ? 2'b10 : 2'b01;
    exp_d  = m_data[idx][w];
    cif.address   = a;
    cif.req_valid = 1'b1;
    if (k_flush_req != 0) flush = 1'b1;
    @(posedge clk); #1;
    cif.req_valid = 1'b0;
    if (k_flush_req != 0) begin
      flush = 1'b0;
      model_flush();
    end
    n_chk++;
    if ({cif.data_valid, cif.cache_miss} !== exp_st) begin
      n_err++;
      $display("FAIL %s_resp a=%h got dv/miss=%b%b exp %b", nm, a, cif.data_valid, cif.cache_miss, exp_st);
    end
    if (hit) begin
      n_chk++;
      if (cif.cache_data_out !== exp_d || cif.cache_adr_out !== a) begin
        n_err++;
        $display("FAIL %s_data got data=%h adr=%h exp data=%h adr=%h", nm, cif.cache_data_out, cif.cache_adr_out, exp_d, a);
      end
    end else if (cif.cache_miss === 1'b1) begin
      serve({a[31:4], 4'h0}, nm);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({cif.data_valid, cif.cache_miss, mem_req_valid, cif.cache_data_out, cif.cache_adr_out, mem_req_adr} !== '0) begin
      n_err++;
      $display("FAIL reset got dv=%b miss=%b req=%b data=%h adr=%h madr=%h exp all 0",
               cif.data_valid, cif.cache_miss, mem_req_valid, cif.cache_data_out, cif.cache_adr_out, mem_req_adr);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_cold_miss();
    fetch(32'h0000_1004, "cold_miss");
    fetch(32'h0000_1004, "cold_rehit");
    n_chk++;
    if (cif.cache_data_out !== 32'h2222_2222) begin
      n_err++;
      $display("FAIL cold_word got %h exp 22222222", cif.cache_data_out);
    end
  endtask

  task automatic test_back_to_back();
    fetch(32'h0000_1000, "b2b0");
    fetch(32'h0000_1008, "b2b1");
    fetch(32'h0000_100C, "b2b2");
  endtask

  task automatic test_conflict();
    fetch(32'h0000_1400, "conf_miss");
    fetch(32'h0000_1408, "conf_hit");
    fetch(32'h0000_1000, "conf_evict");
  endtask

  task automatic test_stall();
    k_stall = 3; k_gap = 3;
    fetch(32'h0000_2008, "stall_miss");
    k_stall = 0; k_gap = 0;
    for (int i = 0; i < 4; i++) fetch(32'h0000_2000 + 32'(4 * i), "stall_hit");
  endtask

  task automatic test_flush_idle();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    model_flush();
    fetch(32'h0000_1000, "flush_idle");
    k_flush_req = 1;
    fetch(32'h0000_1004, "flush_hit");
    k_flush_req = 0;
    fetch(32'h0000_1004, "flush_after_hit");
  endtask

  task automatic test_flush_fill();
    k_flush_beat = 1;
    fetch(32'h0000_3000, "flush_fill");
    k_flush_beat = -1;
    @(posedge clk); #1;
    n_chk++;
    if (mem_req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_fill_idle got req=%b exp 0", mem_req_valid);
    end
    fetch(32'h0000_3000, "flush_fill_rereq");
  endtask

  task automatic test_reset_mid_fill();
    k_rst_beat = 2;
    fetch(32'h0000_4000, "rst_fill");
    k_rst_beat = -1;
    fetch(32'h0000_4000, "rst_rereq");
    fetch(32'h0000_400C, "rst_hit");
  endtask

  task automatic test_random();
    logic [21:0] tags [3];
    logic [31:0] a;
    tags[0] = 22'h1; tags[1] = 22'h2; tags[2] = 22'h5;
    for (int i = 0; i < 150; i++) begin
      a = {tags[$urandom_range(2, 0)], 6'($urandom_range(3, 0)), 4'($urandom_range(15, 0))};
      k_stall = int'($urandom_range(2, 0));
      k_gap   = int'($urandom_range(2, 0));
      k_flush_beat = ($urandom_range(7, 0) == 0) ? int'($urandom_range(3, 0)) : -1;
      if ($urandom_range(15, 0) == 0) begin
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        model_flush();
      end
      fetch(a, "rand");
    end
    k_stall = 0; k_gap = 0; k_flush_beat = -1;
  endtask

  initial begin
    cif.address   = '0;
    cif.req_valid = 1'b0;
    model_flush();
    for (int b = 0; b < 4; b++) begin
      bmem[32'h1000 + 4 * b] = 32'h1111_1111 * (b + 1);
      bmem[32'h1400 + 4 * b] = 32'hAAAA_0000 + b;
    end
    test_reset();
    test_cold_miss();
    test_back_to_back();
    test_conflict();
    test_stall();
    test_flush_idle();
    test_flush_fill();
    test_reset_mid_fill();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
